// File: rtl/mux_scan_if.sv
// Bundle of scan-request, mux feedback and sample handshake signals for mux_scan_ctrl.
interface mux_scan_if;
  logic       en;
  logic [7:0] req;
  logic       mux_y;
  logic       s2;
  logic       s1;
  logic       s0;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_ch;
  logic       out_bit;
  logic       busy;

  // Controller side
  modport slave (
    input  en, req, mux_y, out_ready,
    output s2, s1, s0, out_valid, out_ch, out_bit, busy
  );

  // Requester / consumer side
  modport master (
    output en, req, mux_y, out_ready,
    input  s2, s1, s0, out_valid, out_ch, out_bit, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for a downstream 8:1 mux: grants a requesting channel,
// waits SETTLE cycles for the mux to settle, captures y and holds it until consumed.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_if.slave      bus
);

  localparam int unsigned CH_W  = 3;
  localparam int unsigned N_CH  = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [CH_W-1:0]   sel_q,       sel_d;
  logic [CH_W-1:0]   last_q,      last_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q,   out_bit_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic              busy_q,      busy_d;

  logic              grant_found_c;
  logic [CH_W-1:0]   grant_ch_c;
  logic [CH_W-1:0]   cand_c;

  // Round-robin search: first set req bit at or above last+1, wrapping at 8
  always_comb begin
    grant_found_c = 1'b0;
    grant_ch_c    = '0;
    cand_c        = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand_c = last_q + CH_W'(1) + CH_W'(i);
      if (!grant_found_c && bus.req[cand_c]) begin
        grant_found_c = 1'b1;
        grant_ch_c    = cand_c;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_ch_d    = out_ch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en && grant_found_c) begin
          sel_d   = grant_ch_c;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          out_bit_d   = bus.mux_y;
          out_ch_d    = sel_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (bus.out_ready) begin
          last_d      = sel_q;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // last resets to 7 so the first search begins at channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      last_q      <= CH_W'(N_CH - 1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_ch_q    <= out_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.s2        = sel_q[2];
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=1, one with SETTLE=3.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  mux_scan_if bus_a ();
  mux_scan_if bus_b ();

  mux_scan_ctrl #(.SETTLE(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_scan_ctrl #(.SETTLE(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] sel_a();
    return {bus_a.s2, bus_a.s1, bus_a.s0};
  endfunction

  function automatic logic [2:0] sel_b();
    return {bus_b.s2, bus_b.s1, bus_b.s0};
  endfunction

  logic [2:0] exp_029 [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_029[0] = 3'd2; exp_029[1] = 3'd7; exp_029[2] = 3'd2; exp_029[3] = 3'd7;

    rst_n = 1'b0;
    bus_a.en = 1'b1; bus_a.req = 8'h01; bus_a.mux_y = 1'b1; bus_a.out_ready = 1'b1;
    bus_b.en = 1'b0; bus_b.req = 8'h00; bus_b.mux_y = 1'b0; bus_b.out_ready = 1'b0;
    #12;
    check("rst_sel",   32'(sel_a()),         32'd0);
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy",  32'(bus_a.busy),      32'd0);
    check("rst_ch",    32'(bus_a.out_ch),    32'd0);
    check("rst_bit",   32'(bus_a.out_bit),   32'd0);
    check("rst_busy_b",32'(bus_b.busy),      32'd0);

    // Single channel, back-to-back with one IDLE cycle
    #2 rst_n = 1'b1;
    tick();
    check("e1_sel",   32'(sel_a()),         32'd0);
    check("e1_busy",  32'(bus_a.busy),      32'd1);
    check("e1_valid", 32'(bus_a.out_valid), 32'd0);
    tick();
    check("e2_valid", 32'(bus_a.out_valid), 32'd1);
    check("e2_bit",   32'(bus_a.out_bit),   32'd1);
    check("e2_ch",    32'(bus_a.out_ch),    32'd0);
    tick();
    check("e3_valid", 32'(bus_a.out_valid), 32'd0);
    check("e3_busy",  32'(bus_a.busy),      32'd0);
    tick();
    check("e4_busy",  32'(bus_a.busy),      32'd1);
    check("e4_sel",   32'(sel_a()),         32'd0);
    tick();
    tick();

    // Full round-robin over all eight channels
    bus_a.req = 8'hFF;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus_a.mux_y = k[0];
      tick();
      check("rr_sel", 32'(sel_a()), 32'(k % 8));
      tick();
      check("rr_valid", 32'(bus_a.out_valid), 32'd1);
      check("rr_ch",    32'(bus_a.out_ch),    32'(k % 8));
      check("rr_bit",   32'(bus_a.out_bit),   32'(k[0]));
      tick();
      check("rr_clr",   32'(bus_a.out_valid), 32'd0);
    end

    // Sparse request: only 2 and 7
    bus_a.req = 8'b1000_0100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sp_sel", 32'(sel_a()), 32'(exp_029[k]));
      tick();
      check("sp_ch",  32'(bus_a.out_ch), 32'(exp_029[k]));
      tick();
    end

    // Idle conditions keep the last select (7)
    bus_a.en = 1'b0; bus_a.req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("en0_busy", 32'(bus_a.busy), 32'd0);
      check("en0_sel",  32'(sel_a()),    32'd7);
    end
    check("en0_valid", 32'(bus_a.out_valid), 32'd0);
    bus_a.en = 1'b1; bus_a.req = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("req0_busy", 32'(bus_a.busy), 32'd0);
      check("req0_sel",  32'(sel_a()),    32'd7);
    end
    check("req0_valid", 32'(bus_a.out_valid), 32'd0);

    // Dropping en/req after grant does not abort
    bus_a.req = 8'h08; bus_a.mux_y = 1'b1;
    tick();
    check("ab_sel", 32'(sel_a()), 32'd3);
    bus_a.en = 1'b0; bus_a.req = 8'h00; bus_a.mux_y = 1'b0;
    tick();
    check("ab_valid", 32'(bus_a.out_valid), 32'd1);
    check("ab_ch",    32'(bus_a.out_ch),    32'd3);
    check("ab_bit",   32'(bus_a.out_bit),   32'd0);
    tick();
    check("ab_clr",   32'(bus_a.out_valid), 32'd0);

    // SETTLE=3 instance: latency and hold stability
    bus_a.out_ready = 1'b0;
    do_reset();
    bus_b.en = 1'b1; bus_b.req = 8'h20; bus_b.mux_y = 1'b0;
    tick();
    check("s3_sel",  32'(sel_b()),    32'd5);
    check("s3_busy", 32'(bus_b.busy), 32'd1);
    tick();
    check("s3_v1", 32'(bus_b.out_valid), 32'd0);
    tick();
    check("s3_v2", 32'(bus_b.out_valid), 32'd0);
    bus_b.mux_y = 1'b1;
    bus_b.req   = 8'hFF;
    tick();
    check("s3_v3",  32'(bus_b.out_valid), 32'd1);
    check("s3_bit", 32'(bus_b.out_bit),   32'd1);
    for (int k = 0; k < 5; k++) begin
      bus_b.mux_y = ~bus_b.mux_y;
      tick();
      check("hold_valid", 32'(bus_b.out_valid), 32'd1);
      check("hold_bit",   32'(bus_b.out_bit),   32'd1);
      check("hold_ch",    32'(bus_b.out_ch),    32'd5);
      check("hold_sel",   32'(sel_b()),         32'd5);
    end

    // Async reset mid-HOLD discards the sample
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus_b.out_valid), 32'd0);
    check("ar_sel",   32'(sel_b()),         32'd0);
    check("ar_busy",  32'(bus_b.busy),      32'd0);
    bus_b.req = 8'h10; bus_b.out_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check("ar_grant", 32'(sel_b()),         32'd4);
    check("ar_nv",    32'(bus_b.out_valid), 32'd0);
    tick();
    tick();
    check("ar_nv2",   32'(bus_b.out_valid), 32'd0);
    tick();
    check("ar_v",     32'(bus_b.out_valid), 32'd1);
    check("ar_ch",    32'(bus_b.out_ch),    32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
